rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Parametrised N-input, WIDTH-bit registered selector with a valid/ready handshake on every input channel and on the output.
- Two modes. Fixed mode forwards only the channel named by Sel, like a classic N-to-1 mux. Round-robin mode arbitrates fairly among all valid channels.
- The result is held in one output register stage.
- Used in the datapath wherever several producers share one consumer, for example writeback or memory-request merge.

Parameters:
- WIDTH, 32, data width per channel.
- N, 5, number of input channels (2..16).
- SELW, 3, width of Sel and OutSrc; must satisfy 2**SELW >= N.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Mode  in  1  0 = fixed select, 1 = round-robin.
- Sel  in  SELW  channel to forward in fixed mode; ignored in round-robin mode.
- InValid  in  N  per-channel valid; bit k belongs to channel k.
- InData  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- InReady  out  N  per-channel ready, one-hot or zero.
- OutValid  out  1  output register holds a valid word.
- OutData  out  WIDTH  registered data.
- OutSrc  out  SELW  index of the channel that produced OutData.
- OutReady  in  1  downstream accepts the word.

Behaviour:
- Reset (Reset=0, asynchronous):
  - OutValid=0, OutData=0, OutSrc=0.
  - Round-robin pointer Last=N-1, so channel 0 has top priority after reset.
  - Reset mid-transfer discards the held word; no handshake completes in that cycle.
- Load enable: Load = !OutValid || OutReady. The register accepts a new word whenever it is empty or being drained in the same cycle (full throughput, 1 word per cycle).
- Eligibility:
  - Fixed mode: only channel Sel is eligible.
  - Sel >= N: no channel is eligible and no grant is made.
  - Round-robin mode: every channel with InValid=1 is eligible.
- Grant, combinational:
  - Fixed mode: G = Sel if InValid[Sel] && Load.
  - Round-robin mode: G is the first eligible channel scanning Last+1, Last+2, ... with modulo-N wrap. Granted only if Load.
  - InReady[G]=1; all other InReady bits are 0. With no grant, InReady is all 0.
  - InReady never depends on InValid of another channel in fixed mode.
- Transfer on the clock edge:
  - Grant: OutData<=InData[G], OutSrc<=G, OutValid<=1. In round-robin mode, Last<=G.
  - Load without grant: OutValid<=0. OutData and OutSrc hold their previous values.
  - !Load (OutValid=1, OutReady=0): the register and Last hold. OutData/OutSrc are stable while OutValid=1.
- Latency: 1 cycle from input handshake to OutValid.
- Pointer rules:
  - Last updates only on round-robin grants.
  - Fixed-mode grants leave Last untouched, so returning to round-robin resumes the prior rotation.
- Mode and Sel are sampled each cycle. A change affects only the next grant, never the word already held.
- Fairness: with all N channels continuously valid and OutReady=1, round-robin grants 0,1,...,N-1,0,... Each channel waits at most N-1 grants.
- A single valid channel in round-robin mode is granted every cycle regardless of Last.

Decomposition:
- Shared package holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - Default WIDTH/N/SELW.
  - A function for the modulo-N increment.
- Sub-module rr_priority_pick, purely combinational:
  - Inputs: request vector [N], base pointer [SELW].
  - Outputs: found flag, index [SELW].
  - Implemented as a doubled request vector with rotate and priority encode.
- Top level holds the mode mux, grant/ready generation, output register and the Last pointer.

Test Plan (N=5, WIDTH=32, InData channel k = 32'h10*k):
1. Fixed mode, Sel=0..4 in turn, only the selected channel valid, OutReady=1 -> one cycle later OutData=00000000, 00000010, 00000020, 00000030, 00000040; OutSrc matches Sel.
2. Fixed mode, Sel=3'b101 (>=N), all InValid=1 -> InReady=0 every cycle; OutValid goes 0 after draining.
3. Round-robin mode, InValid=5'b11111, OutReady=1 for 10 cycles -> OutSrc sequence 0,1,2,3,4,0,1,2,3,4; OutData=00000000, 00000010, ... correspondingly.
4. Round-robin mode, grant channel 2, then hold OutReady=0 for 3 cycles -> OutValid=1, OutData=00000020 stable, InReady=0. On release, the next grant is channel 3 (InValid=5'b11111).
5. Round-robin mode, InValid=5'b10001 after a grant to channel 4 -> the next grant is channel 0, then channel 4. Covers wrap-around.
6. Assert Reset=0 asynchronously between clock edges while OutValid=1 -> OutValid=0 and OutData=0 immediately. After release with InValid=5'b11111, the first grant is channel 0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select output arbiter.
package rr_mux_arbiter_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 5;
    localparam int DEFAULT_SELW  = 3;

    // Next channel index after idx, wrapping back to 0 at n.
    function automatic int mod_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating priority encoder: first set request at or after base, with wrap-around.
module rr_priority_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int SELW = DEFAULT_SELW
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] base,
    output logic            found,
    output logic [SELW-1:0] index
);

    localparam int IW = $clog2(2 * N);
    localparam logic [SELW:0] N_W = (SELW + 1)'(N);

    logic [2*N-1:0]  doubled;
    logic [IW-1:0]   pos;
    logic [SELW-1:0] offset;
    logic [SELW:0]   sum;

    // Doubling the vector lets a plain scan from base cover the wrap without modulo logic.
    always_comb begin
        doubled = {req, req};
        found   = 1'b0;
        offset  = '0;
        pos     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = IW'(base) + IW'(i);
            if (doubled[pos]) begin
                found  = 1'b1;
                offset = SELW'(i);
            end
        end
        sum = {1'b0, base} + {1'b0, offset};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        index = sum[SELW-1:0];
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-input registered selector: fixed Sel forwarding or round-robin arbitration, one output stage.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SELW  = DEFAULT_SELW
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Mode,
    input  logic [SELW-1:0]    Sel,
    input  logic [N-1:0]       InValid,
    input  logic [N*WIDTH-1:0] InData,
    output logic [N-1:0]       InReady,
    output logic               OutValid,
    output logic [WIDTH-1:0]   OutData,
    output logic [SELW-1:0]    OutSrc,
    input  logic               OutReady
);

    // Handshake: a word moves on a rising edge when valid and ready are both high in that
    // cycle; ready may depend on valid (round-robin), valid must not wait on ready.

    logic             load;
    logic             fixed_valid;
    logic             rr_found;
    logic [SELW-1:0]  rr_index;
    logic [SELW-1:0]  rr_start;
    logic [SELW-1:0]  last;
    logic             grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign load     = !OutValid || OutReady;
    assign rr_start = SELW'(mod_inc(int'(last), N));

    rr_priority_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req   (InValid),
        .base  (rr_start),
        .found (rr_found),
        .index (rr_index)
    );

    // Sel values at or above N match no channel, so they never produce a grant.
    always_comb begin
        fixed_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (Sel == SELW'(k)) begin
                fixed_valid = InValid[k];
            end
        end
    end

    assign grant     = load && ((Mode == MODE_RR) ? rr_found : fixed_valid);
    assign grant_idx = (Mode == MODE_RR) ? rr_index : Sel;

    always_comb begin
        InReady    = '0;
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == SELW'(k)) begin
                InReady[k] = grant;
                grant_data = InData[k*WIDTH +: WIDTH];
            end
        end
    end

    // Last only advances on round-robin grants so fixed-mode traffic does not disturb rotation.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            OutValid <= 1'b0;
            OutData  <= '0;
            OutSrc   <= '0;
            last     <= SELW'(N - 1);
        end else if (load) begin
            if (grant) begin
                OutValid <= 1'b1;
                OutData  <= grant_data;
                OutSrc   <= grant_idx;
                if (Mode == MODE_RR) begin
                    last <= grant_idx;
                end
            end else begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed plan steps, then random traffic vs a reference model.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 32;
    localparam int N     = 5;
    localparam int SELW  = 3;

    logic               clk;
    logic               rst_n;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] chan[N];
    logic [WIDTH-1:0] exp_q[$];

    // Reference model state
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    int               m_last;

    rr_mux_arbiter #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .Mode     (mode),
        .Sel      (sel),
        .InValid  (in_valid),
        .InData   (in_data),
        .InReady  (in_ready),
        .OutValid (out_valid),
        .OutData  (out_data),
        .OutSrc   (out_src),
        .OutReady (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input bit md, input int s, input logic [N-1:0] v,
                                       input bit ld, input int lst);
        if (!ld) return -1;
        if (md == 1'b0) begin
            if (s < N && v[s]) return s;
            return -1;
        end
        for (int off = 1; off <= N; off++) begin
            if (v[(lst + off) % N]) return (lst + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_last  = N - 1;
        exp_q.delete();
    endtask

    task automatic pack_data();
        for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = chan[k];
    endtask

    task automatic drive(input bit md, input int s, input logic [N-1:0] v, input bit rdy);
        mode      = md;
        sel       = SELW'(s);
        in_valid  = v;
        out_ready = rdy;
        pack_data();
    endtask

    // One clock: check ready and outgoing words before the edge, then register state after it.
    task automatic cycle();
        bit             ld;
        int             g;
        logic [N-1:0]   exp_ready;
        logic [WIDTH-1:0] front;
        #1;
        ld = !m_valid || out_ready;
        g  = model_grant(mode, int'(sel), in_valid, ld, m_last);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 64'(1), 64'(0));
            end else begin
                front = exp_q.pop_front();
                check("scoreboard_data", 64'(out_data), 64'(front));
            end
        end
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = chan[g];
                m_src   = g;
                if (mode) m_last = g;
                exp_q.push_back(chan[g]);
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_data", 64'(out_data), 64'(m_data));
            check("out_src", 64'(out_src), 64'(m_src));
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) chan[k] = 32'h10 * k;
        drive(1'b0, 0, '0, 1'b1);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data", 64'(out_data), 64'(0));
        check("reset_out_src", 64'(out_src), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: fixed mode, walk Sel with only that channel valid
        for (int s = 0; s < N; s++) begin
            drive(1'b0, s, 5'b00001 << s, 1'b1);
            cycle();
            check("fixed_sel_data", 64'(out_data), 64'(32'h10 * s));
            check("fixed_sel_src", 64'(out_src), 64'(s));
        end

        // 2: fixed mode, out-of-range Sel, everyone valid
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5, 5'b11111, 1'b1);
            cycle();
            check("sel_oob_ready", 64'(in_ready), 64'(0));
        end
        check("sel_oob_drained", 64'(out_valid), 64'(0));

        // 3: round-robin fairness; earlier fixed grants left the pointer at reset value
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 0, 5'b11111, 1'b1);
            cycle();
            check("rr_seq_src", 64'(out_src), 64'(i % N));
            check("rr_seq_data", 64'(out_data), 64'(32'h10 * (i % N)));
        end

        // 4: grant 2 then backpressure for 3 cycles
        drive(1'b1, 0, 5'b00100, 1'b1);
        cycle();
        check("bp_grant2", 64'(out_src), 64'(2));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 5'b11111, 1'b0);
            cycle();
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_data", 64'(out_data), 64'(32'h20));
        end
        drive(1'b1, 0, 5'b11111, 1'b1);
        cycle();
        check("bp_release_src", 64'(out_src), 64'(3));

        // 5: wrap-around from channel 4
        drive(1'b1, 0, 5'b10000, 1'b1);
        cycle();
        check("wrap_grant4", 64'(out_src), 64'(4));
        drive(1'b1, 0, 5'b10001, 1'b1);
        cycle();
        check("wrap_then0", 64'(out_src), 64'(0));
        cycle();
        check("wrap_then4", 64'(out_src), 64'(4));

        // 6: asynchronous reset between edges while holding a word
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_data", 64'(out_data), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 0, 5'b11111, 1'b1);
        cycle();
        check("post_reset_first", 64'(out_src), 64'(0));

        // Random traffic: modes, Sel (incl. out-of-range), valids, backpressure, data
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) chan[k] = $urandom;
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  N'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
